// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: operands, opcode, start strobe,
// status and flags. The tri-state result bus and its enable stay on the module.
interface alu_multicycle_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       sel;
    logic [WIDTH-1:0] reg_A;
    logic [WIDTH-1:0] reg_B;
    logic             busy;
    logic             done;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_dz;

    modport master (
        output start, sel, reg_A, reg_B,
        input  busy, done, flag_z, flag_c, flag_v, flag_dz
    );

    modport slave (
        input  start, sel, reg_A, reg_B,
        output busy, done, flag_z, flag_c, flag_v, flag_dz
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle add/sub/logic ops, WIDTH-iteration shift-add multiply
// and restoring divide, registered result/flags, result driven onto a tri-state bus.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    inout  wire  [WIDTH-1:0] bus,
    alu_multicycle_if.slave  io
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               flag_z_q,  flag_z_d;
    logic               flag_c_q,  flag_c_d;
    logic               flag_v_q,  flag_v_d;
    logic               flag_dz_q, flag_dz_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               is_div_q,  is_div_d;
    logic [WIDTH-1:0]   opb_q,     opb_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;

    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH-1:0]   quick_res_s;
    logic               quick_c_s;
    logic               quick_v_s;
    logic               quick_dz_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic               long_op_s;

    // Single-cycle datapath evaluated directly on the sampled operands.
    always_comb begin
        add_s       = {1'b0, io.reg_A} + {1'b0, io.reg_B};
        sub_s       = {1'b0, io.reg_A} - {1'b0, io.reg_B};
        quick_res_s = {WIDTH{1'b0}};
        quick_c_s   = 1'b0;
        quick_v_s   = 1'b0;
        quick_dz_s  = 1'b0;
        case (io.sel)
            OP_ADD: begin
                quick_res_s = add_s[WIDTH-1:0];
                quick_c_s   = add_s[WIDTH];
                quick_v_s   = (io.reg_A[WIDTH-1] == io.reg_B[WIDTH-1]) &&
                              (add_s[WIDTH-1] != io.reg_A[WIDTH-1]);
            end
            OP_SUB: begin
                quick_res_s = sub_s[WIDTH-1:0];
                quick_c_s   = sub_s[WIDTH];
                quick_v_s   = (io.reg_A[WIDTH-1] != io.reg_B[WIDTH-1]) &&
                              (sub_s[WIDTH-1] != io.reg_A[WIDTH-1]);
            end
            OP_DIV: begin
                // Only reaches the result register for a zero divisor.
                quick_res_s = {WIDTH{1'b1}};
                quick_dz_s  = 1'b1;
            end
            OP_AND:  quick_res_s = io.reg_A & io.reg_B;
            OP_OR:   quick_res_s = io.reg_A | io.reg_B;
            OP_XOR:  quick_res_s = io.reg_A ^ io.reg_B;
            OP_PASS: quick_res_s = io.reg_A;
            default: quick_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One multiply or divide iteration on the accumulator {high, low}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_diff_s[WIDTH]) begin
                acc_nxt_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
    end

    // Control FSM and next-state for result, flags and iteration state.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;
        flag_dz_d = flag_dz_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        long_op_s = (io.sel == OP_MUL) ||
                    ((io.sel == OP_DIV) && (io.reg_B != {WIDTH{1'b0}}));
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (io.start) begin
                    if (long_op_s) begin
                        state_d  = ST_EXEC;
                        busy_d   = 1'b1;
                        cnt_d    = {CW{1'b0}};
                        is_div_d = (io.sel == OP_DIV);
                        opb_d    = io.reg_B;
                        acc_d    = {{WIDTH{1'b0}}, io.reg_A};
                    end else begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        result_d  = quick_res_s;
                        flag_z_d  = (quick_res_s == {WIDTH{1'b0}});
                        flag_c_d  = quick_c_s;
                        flag_v_d  = quick_v_s;
                        flag_dz_d = quick_dz_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                acc_d = acc_nxt_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    result_d  = acc_nxt_s[WIDTH-1:0];
                    flag_z_d  = (acc_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    flag_c_d  = 1'b0;
                    flag_v_d  = is_div_q ? 1'b0 : (|acc_nxt_s[2*WIDTH-1:WIDTH]);
                    flag_dz_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= {WIDTH{1'b0}};
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            flag_dz_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            is_div_q  <= 1'b0;
            opb_q     <= {WIDTH{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            flag_v_q  <= flag_v_d;
            flag_dz_q <= flag_dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
        end
    end

    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.flag_z  = flag_z_q;
    assign io.flag_c  = flag_c_q;
    assign io.flag_v  = flag_v_q;
    assign io.flag_dz = flag_dz_q;

    assign bus = en ? result_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle (WIDTH=8) against an
// arithmetic reference model, plus directed corner cases and reset abort.
module tb_alu_multicycle;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tb_drv_en;
    logic [7:0] tb_drv;
    wire  [7:0] bus;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] prev_res;
    logic [3:0] prev_flags;

    alu_multicycle_if #(.WIDTH(W)) io();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus),
        .io  (io)
    );

    // A second bus master, used to prove the DUT releases the bus.
    assign bus = tb_drv_en ? tb_drv : 8'hzz;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] s, input int a, input int b,
                                    output logic [7:0] r, output logic [3:0] flags,
                                    output int lat);
        int t;
        int sa;
        int sb;
        logic z, c, v, dz;
        sa  = (a > 127) ? a - 256 : a;
        sb  = (b > 127) ? b - 256 : b;
        c   = 1'b0;
        v   = 1'b0;
        dz  = 1'b0;
        lat = 1;
        case (s)
            3'd0: begin t = a + b; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin t = a - b; c = (a < b);   v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: begin t = a * b; v = (t > 255); lat = W + 1; end
            3'd3: begin
                if (b == 0) begin t = 255; dz = 1'b1; end
                else begin t = a / b; lat = W + 1; end
            end
            3'd4: t = a & b;
            3'd5: t = a | b;
            3'd6: t = a ^ b;
            default: t = a;
        endcase
        r     = 8'(t & 255);
        z     = (r == 8'd0);
        flags = {z, c, v, dz};
    endfunction

    task automatic run_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                          input bit scramble);
        logic [7:0] er;
        logic [3:0] ef;
        int elat;
        int lat;
        bit got;
        ref_alu(s, int'(a), int'(b), er, ef, elat);
        io.start = 1'b1;
        io.sel   = s;
        io.reg_A = a;
        io.reg_B = b;
        lat = 0;
        got = 1'b0;
        while (!got && lat < W + 6) begin
            @(negedge clk);
            lat++;
            chk("busy_done_excl", {31'd0, io.busy & io.done}, 32'd0);
            if (io.done) begin
                got = 1'b1;
                io.start = 1'b0;
            end else begin
                chk("busy", {31'd0, io.busy}, {31'd0, elat > 1});
                chk("hold_result", {24'd0, bus}, {24'd0, prev_res});
                chk("hold_flags", {28'd0, io.flag_z, io.flag_c, io.flag_v, io.flag_dz},
                    {28'd0, prev_flags});
                if (scramble) begin
                    io.start = 1'($urandom_range(0, 1));
                    io.sel   = 3'($urandom);
                    io.reg_A = 8'($urandom);
                    io.reg_B = 8'($urandom);
                end else begin
                    io.start = 1'b0;
                end
            end
        end
        io.start = 1'b0;
        chk("latency", lat, elat);
        chk("result", {24'd0, bus}, {24'd0, er});
        chk("flags", {28'd0, io.flag_z, io.flag_c, io.flag_v, io.flag_dz}, {28'd0, ef});
        prev_res   = er;
        prev_flags = ef;
    endtask

    initial begin
        int dones;
        logic [7:0] rb;
        rst       = 1'b1;
        en        = 1'b1;
        tb_drv_en = 1'b0;
        tb_drv    = 8'h00;
        io.start  = 1'b0;
        io.sel    = 3'd0;
        io.reg_A  = 8'd0;
        io.reg_B  = 8'd0;
        prev_res   = 8'd0;
        prev_flags = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, io.busy}, 32'd0);
        chk("reset_done", {31'd0, io.done}, 32'd0);
        chk("reset_flags", {28'd0, io.flag_z, io.flag_c, io.flag_v, io.flag_dz}, 32'd0);
        chk("reset_bus", {24'd0, bus}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 8'd200, 8'd100, 1'b0);
        @(negedge clk);
        en = 1'b0; tb_drv = 8'h53; tb_drv_en = 1'b1;
        #1 chk("bus_release0", {24'd0, bus}, 32'h53);
        tb_drv_en = 1'b0; en = 1'b1;
        #1 chk("bus_drive", {24'd0, bus}, 32'h2C);
        en = 1'b0; tb_drv_en = 1'b1;
        #1 chk("bus_release1", {24'd0, bus}, 32'h53);
        tb_drv_en = 1'b0; en = 1'b1;
        @(negedge clk);

        // Back-to-back directed corner cases.
        run_op(3'd1, 8'd5,    8'd7,    1'b0);
        run_op(3'd1, 8'h80,   8'h01,   1'b0);
        run_op(3'd2, 8'd15,   8'd17,   1'b1);
        run_op(3'd2, 8'd16,   8'd16,   1'b0);
        run_op(3'd3, 8'd100,  8'd7,    1'b1);
        run_op(3'd3, 8'd9,    8'd0,    1'b0);
        run_op(3'd3, 8'd255,  8'd1,    1'b0);
        run_op(3'd2, 8'd255,  8'd255,  1'b0);
        run_op(3'd0, 8'h7F,   8'h01,   1'b0);

        for (int i = 0; i < 60; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            run_op(3'($urandom), 8'($urandom), rb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a multiply; ADD pulse during EXEC must be ignored.
        @(negedge clk);
        io.start = 1'b1; io.sel = 3'd2; io.reg_A = 8'd15; io.reg_B = 8'd17;
        @(negedge clk); io.start = 1'b0;
        @(negedge clk);
        @(negedge clk); io.start = 1'b1; io.sel = 3'd0; io.reg_A = 8'd1; io.reg_B = 8'd2;
        @(negedge clk); io.start = 1'b0;
        chk("abort_no_done_early", {31'd0, io.done}, 32'd0);
        @(negedge clk);
        chk("abort_busy", {31'd0, io.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_rst_busy", {31'd0, io.busy}, 32'd0);
        chk("abort_rst_done", {31'd0, io.done}, 32'd0);
        chk("abort_rst_flags", {28'd0, io.flag_z, io.flag_c, io.flag_v, io.flag_dz}, 32'd0);
        chk("abort_rst_bus", {24'd0, bus}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_res   = 8'd0;
        prev_flags = 4'd0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            dones += int'(io.done);
        end
        chk("abort_no_done", dones, 0);
        run_op(3'd0, 8'd3, 8'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result/bus width in bits (legal range 4..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled on rising clk edge.
REQ-005 sel  input  3  opcode, sampled with start: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 PASS A.
REQ-006 reg_A  input  WIDTH  operand A, unsigned, sampled with start.
REQ-007 reg_B  input  WIDTH  operand B, unsigned, sampled with start.
REQ-008 en  input  1  bus drive enable.
REQ-009 bus  inout  WIDTH  bidirectional bus; carries result register when en=1, high-Z when en=0.
REQ-010 busy  output  1  operation in progress; start ignored while high.
REQ-011 done  output  1  single-cycle pulse: result and flags valid and updated.
REQ-012 flag_z, flag_c, flag_v, flag_dz  output  1 each  zero, carry/borrow, overflow, divide-by-zero.

Function
REQ-013 FSM states: IDLE, EXEC, DONE; reset enters IDLE.
REQ-014 IDLE + start=1 + sel in {ADD,SUB,AND,OR,XOR,PASS}: next edge writes result and flags, enters DONE; done=1 that cycle (latency 1).
REQ-015 IDLE + start=1 + sel in {MUL,DIV} with B!=0: latch operands, clear iteration counter, enter EXEC, busy=1.
REQ-016 EXEC performs exactly one iteration per cycle for WIDTH cycles (MUL shift-add, DIV restoring), then enters DONE with result written; start-to-done latency WIDTH+1 cycles.
REQ-017 DONE lasts exactly one cycle, then IDLE; a start in DONE cycle is accepted as if in IDLE (back-to-back).
REQ-018 start while busy=1 is ignored; sel/reg_A/reg_B changes during EXEC do not affect the result.
REQ-019 busy=1 in EXEC only; done=1 in DONE only; never both high.
REQ-020 ADD: result = (A+B) mod 2^WIDTH; flag_c = carry out; flag_v = signed overflow (two's-complement view).
REQ-021 SUB: result = (A-B) mod 2^WIDTH; flag_c = 1 when A<B (borrow); flag_v = signed overflow.
REQ-022 MUL: result = low WIDTH bits of A*B; flag_v = 1 when high WIDTH bits nonzero; flag_c = 0.
REQ-023 DIV: result = floor(A/B), remainder discarded; flag_c = flag_v = 0.
REQ-024 DIV with B=0: no EXEC; latency 1; result all ones; flag_dz=1; other flags 0 except flag_z computed normally.
REQ-025 AND/OR/XOR/PASS: bitwise result; flag_c = flag_v = 0.
REQ-026 flag_z = (result == 0) for every op; flag_dz = 0 for every op except REQ-024.
REQ-027 Result and flags hold last completed value until next done; they do not change during EXEC.
REQ-028 bus driven from result register whenever en=1, in any state, including during EXEC (shows previous result).

Reset
REQ-029 rst=1 asynchronously forces IDLE, result=0, busy=0, done=0, all flags 0, iteration counter 0; bus follows en.
REQ-030 rst asserted mid-EXEC aborts the operation; no done pulse after release; next start behaves normally.

Verification (WIDTH=8)
REQ-031 ADD A=200 B=100 -> done 1 cycle after start, result 0x2C, flag_c=1, flag_v=0, flag_z=0.
REQ-032 SUB A=5 B=7 -> result 0xFE, flag_c=1; SUB A=0x80 B=0x01 -> result 0x7F, flag_v=1.
REQ-033 MUL 15*17 -> busy 8 cycles, done at start+9, result 0xFF, flag_v=0; MUL 16*16 -> result 0x00, flag_v=1, flag_z=1.
REQ-034 DIV 100/7 -> result 14 at start+9; DIV 9/0 -> result 0xFF, flag_dz=1 at start+1, busy never high.
REQ-035 Start MUL, pulse start with ADD at cycle 3, assert rst at cycle 5 -> ADD ignored, no done, all outputs 0 after rst.
REQ-036 en toggled 0/1/0 with result 0x2C -> bus Z, 0x2C, Z; back-to-back start in DONE cycle accepted.
